// File: rtl/det_ctrl_pkg.sv
//------------------------------------------------------------------------------
// det_ctrl_pkg : shared types, defaults and helpers for detector_stream_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package det_ctrl_pkg;

    localparam int DEF_PAT_W = 16;
    localparam int DEF_LEN_W = 5;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
//------------------------------------------------------------------------------
// rr_arbiter2 : two-way round-robin arbiter holding the last-served pointer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_idx,
    output logic       gnt_any
);

    logic r_last;

    always_comb begin
        gnt_any = |req;
        if (req == 2'b11) begin
            gnt_idx = ~r_last;
        end else begin
            gnt_idx = req[1];
        end
    end

    // Last-served starts at 1 so requester 0 wins the first contention
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (take && gnt_any) begin
            r_last <= gnt_idx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/detector_stream_ctrl.sv
//------------------------------------------------------------------------------
// detector_stream_ctrl : shares one serial sequence detector between two
// requesters, shifting each pattern LSB first and counting detector matches.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module detector_stream_ctrl
    import det_ctrl_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [PAT_W-1:0] pat0,
    input  logic [PAT_W-1:0] pat1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic             det_clr,
    output logic             det_en,
    output logic             det_w,
    input  logic             det_z,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] match_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_gnt;
    logic [1:0]       w_gnt_n;
    logic             r_det_clr, w_clr_n;
    logic             r_det_en, w_en_n;
    logic             r_det_w, w_w_n;
    logic             r_busy, w_busy_n;
    logic             r_done, w_done_n;
    logic             r_done_id;
    logic             r_q;
    logic             r_id;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             w_take;
    logic             w_arb_idx;
    logic             w_arb_any;
    logic             w_accept;
    logic [PAT_W-1:0] w_pat_sel;
    logic [LEN_W-1:0] w_len_sel;
    logic [LEN_W-1:0] w_len_clamped;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .take    (w_take),
        .gnt_idx (w_arb_idx),
        .gnt_any (w_arb_any)
    );

    // The grant decided on the previous edge is being presented this cycle
    assign w_accept      = (r_state == IDLE) && (r_gnt != 2'b00);
    assign w_pat_sel     = r_gnt[1] ? pat1 : pat0;
    assign w_len_sel     = r_gnt[1] ? len1 : len0;
    assign w_len_clamped = LEN_W'(clamp_len(32'(w_len_sel), 32'(PAT_W)));

    always_comb begin
        w_next   = r_state;
        w_gnt_n  = 2'b00;
        w_clr_n  = 1'b0;
        w_en_n   = 1'b0;
        w_w_n    = 1'b0;
        w_done_n = 1'b0;
        w_take   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_gnt != 2'b00) begin
                    w_next  = CLEAR;
                    w_clr_n = 1'b1;
                end else if (w_arb_any) begin
                    w_take  = 1'b1;
                    w_gnt_n = w_arb_idx ? 2'b10 : 2'b01;
                end
            end
            CLEAR: begin
                if (r_len == '0) begin
                    w_next = DRAIN;
                end else begin
                    w_next = SHIFT;
                    w_en_n = 1'b1;
                    w_w_n  = r_pat[0];
                end
            end
            SHIFT: begin
                if (r_idx == r_len) begin
                    w_next = DRAIN;
                end else begin
                    w_en_n = 1'b1;
                    w_w_n  = r_pat[0];
                end
            end
            DRAIN: begin
                w_next   = DONE;
                w_done_n = 1'b1;
            end
            DONE: begin
                // Decide here so the grant lands in the IDLE cycle right after DONE
                w_next = IDLE;
                if (w_arb_any) begin
                    w_take  = 1'b1;
                    w_gnt_n = w_arb_idx ? 2'b10 : 2'b01;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        w_busy_n = (w_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_gnt     <= 2'b00;
            r_det_clr <= 1'b1;
            r_det_en  <= 1'b0;
            r_det_w   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_q       <= 1'b0;
            r_id      <= 1'b0;
            r_pat     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_gnt     <= w_gnt_n;
            r_det_clr <= w_clr_n;
            r_det_en  <= w_en_n;
            r_det_w   <= w_w_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
            r_q       <= r_det_en;
            if (w_accept) begin
                r_pat <= w_pat_sel;
                r_len <= w_len_clamped;
                r_id  <= r_gnt[1];
                r_idx <= '0;
                r_cnt <= '0;
            end else begin
                if (w_en_n) begin
                    r_pat <= {1'b0, r_pat[PAT_W-1:1]};
                    r_idx <= r_idx + LEN_W'(1);
                end
                // q lines up with the detector output produced by the previous enabled bit
                if (r_q && det_z && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (r_state == DRAIN) begin
                r_done_id <= r_id;
            end
        end
    end

    assign gnt       = r_gnt;
    assign det_clr   = r_det_clr;
    assign det_en    = r_det_en;
    assign det_w     = r_det_w;
    assign busy      = r_busy;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign match_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_detector_stream_ctrl.sv
//------------------------------------------------------------------------------
// tb_detector_stream_ctrl : randomized two-requester traffic against a job-level
// reference model, with a stub detector (z follows w) per DUT instance.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_detector_stream_ctrl;

    localparam int PAT_W  = 16;
    localparam int LEN_W  = 5;
    localparam int CNT_W  = 5;
    localparam int CNT_S  = 3;
    localparam int NCYC   = 4000;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [PAT_W-1:0] pat0, pat1;
    logic [LEN_W-1:0] len0, len1;

    logic [1:0]       gnt, gnt_s;
    logic             det_clr, det_en, det_w, det_z, busy, done, done_id;
    logic             det_clr_s, det_en_s, det_w_s, det_z_s, busy_s, done_s, done_id_s;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_S-1:0] match_cnt_s;

    always #5 clk = ~clk;

    detector_stream_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req(req), .pat0(pat0), .pat1(pat1),
        .len0(len0), .len1(len1), .gnt(gnt), .det_clr(det_clr), .det_en(det_en),
        .det_w(det_w), .det_z(det_z), .busy(busy), .done(done), .done_id(done_id),
        .match_cnt(match_cnt)
    );

    detector_stream_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_S)) dut_s (
        .clk(clk), .reset(reset), .req(req), .pat0(pat0), .pat1(pat1),
        .len0(len0), .len1(len1), .gnt(gnt_s), .det_clr(det_clr_s), .det_en(det_en_s),
        .det_w(det_w_s), .det_z(det_z_s), .busy(busy_s), .done(done_s), .done_id(done_id_s),
        .match_cnt(match_cnt_s)
    );

    always_ff @(posedge clk) begin
        if (det_clr) det_z <= 1'b0;
        else if (det_en) det_z <= det_w;
    end

    always_ff @(posedge clk) begin
        if (det_clr_s) det_z_s <= 1'b0;
        else if (det_en_s) det_z_s <= det_w_s;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int exp_count(input logic [PAT_W-1:0] p, input int l, input int maxv);
        int n = 0;
        for (int i = 0; i < l; i++) n += int'(p[i]);
        return (n > maxv) ? maxv : n;
    endfunction

    // Job-level model state
    bit               jv;
    int               g, jl, jid, k, earliest, m_last, win, raw_len;
    logic [PAT_W-1:0] jp;
    int               hold, hold_s;
    bit               rst_prev;
    logic [1:0]       req_prev;
    logic [1:0]       e_gnt;
    logic             e_clr, e_en, e_w, e_busy, e_done;
    int               rst_cnt, inj;

    initial begin
        reset    = 1'b1;
        req      = 2'b00;
        pat0     = '0; pat1 = '0; len0 = '0; len1 = '0;
        rst_prev = 1'b1;
        req_prev = 2'b00;
        jv = 0; g = 0; jl = 0; jid = 0; jp = '0; k = 0;
        earliest = 0; m_last = 1; hold = 0; hold_s = 0;
        rst_cnt = 0; inj = 0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            e_gnt = 2'b00;
            if (rst_prev) begin
                chk($sformatf("rst_outs@%0d", c),
                    int'({gnt, det_clr, det_en, det_w, busy, done}), int'(7'b0010000));
                chk($sformatf("rst_cnt@%0d", c), int'(match_cnt), 0);
                chk($sformatf("rst_cnt_s@%0d", c), int'(match_cnt_s), 0);
                chk($sformatf("rst_id@%0d", c), int'(done_id), 0);
                jv = 0; earliest = c + 1; m_last = 1; hold = 0; hold_s = 0;
            end else begin
                if (c >= earliest && req_prev != 2'b00) begin
                    win      = (req_prev == 2'b11) ? (1 - m_last) : int'(req_prev[1]);
                    e_gnt    = (win == 1) ? 2'b10 : 2'b01;
                    m_last   = win;
                    jv       = 1;
                    g        = c;
                    jid      = win;
                    jp       = (win == 1) ? pat1 : pat0;
                    raw_len  = (win == 1) ? int'(len1) : int'(len0);
                    jl       = (raw_len > PAT_W) ? PAT_W : raw_len;
                    earliest = c + jl + 4;
                end
                k      = c - g;
                e_clr  = jv && (k == 1);
                e_en   = jv && (k >= 2) && (k <= jl + 1);
                e_w    = e_en ? jp[k-2] : 1'b0;
                e_busy = jv && (k >= 1) && (k <= jl + 3);
                e_done = jv && (k == jl + 3);
                if (e_done) begin
                    hold   = exp_count(jp, jl, (1 << CNT_W) - 1);
                    hold_s = exp_count(jp, jl, (1 << CNT_S) - 1);
                end
                chk($sformatf("outs@%0d", c),
                    int'({gnt, det_clr, det_en, det_w, busy, done}),
                    int'({e_gnt, e_clr, e_en, e_w, e_busy, e_done}));
                chk($sformatf("outs_s@%0d", c), int'({gnt_s, done_s}), int'({e_gnt, e_done}));
                if (e_done) begin
                    chk($sformatf("done_id@%0d", c), int'(done_id), jid);
                    chk($sformatf("done_id_s@%0d", c), int'(done_id_s), jid);
                end
                if (!jv || k <= 0 || k >= jl + 3) begin
                    chk($sformatf("match_cnt@%0d", c), int'(match_cnt), hold);
                    chk($sformatf("match_cnt_s@%0d", c), int'(match_cnt_s), hold_s);
                end
                // Abort a job in the middle of its shift phase, twice per run
                if (rst_cnt == 0 && e_en && jl >= 6 && k == 4 &&
                    ((inj == 0 && c > 1000) || (inj == 1 && c > 2500))) begin
                    rst_cnt = 2;
                    inj++;
                end
            end

            if (c == 2) begin
                req  = 2'b11;
                pat0 = 16'h00F5; len0 = 5'd8;
                pat1 = 16'hFFFF; len1 = 5'd31;
            end else if (c > 2) begin
                for (int i = 0; i < 2; i++) begin
                    if (req[i] && e_gnt[i]) begin
                        req[i] = 1'b0;
                    end else if (!req[i] && $urandom_range(0, 5) == 0) begin
                        raw_len = int'($urandom_range(0, 9));
                        if (raw_len == 0) raw_len = 0;
                        else if (raw_len == 1) raw_len = int'($urandom_range(17, 31));
                        else raw_len = int'($urandom_range(1, 16));
                        if (i == 0) begin
                            pat0 = PAT_W'($urandom);
                            len0 = LEN_W'(raw_len);
                        end else begin
                            pat1 = PAT_W'($urandom);
                            len1 = LEN_W'(raw_len);
                        end
                        req[i] = 1'b1;
                    end
                end
            end

            if (c < 2) begin
                reset = 1'b1;
            end else if (rst_cnt > 0) begin
                reset = 1'b1;
                rst_cnt--;
            end else begin
                reset = 1'b0;
            end
            rst_prev = reset;
            req_prev = req;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
